// File: rtl/row_stage_sequencer_if.sv
// Request, stage-engine handshake and status bundle for row_stage_sequencer.
// The sequencer takes the slave view; the frame controller or bench takes the master view.
interface row_stage_sequencer_if #(
    parameter int HEIGHT_W = 9,
    parameter int NSTAGE   = 3
);
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    logic                req_i;
    logic [HEIGHT_W-1:0] height_i;
    logic                abort_i;
    logic [NSTAGE-1:0]   stage_done_i;

    logic                pos_req_o;
    logic [NSTAGE-1:0]   stage_start_o;
    logic                ack_o;
    logic                err_o;
    logic [SW-1:0]       err_stage_o;
    logic                aborted_o;
    logic                busy_o;
    logic [HEIGHT_W-1:0] row_o;
    logic [SW-1:0]       stage_o;

    modport master (
        output req_i,
        output height_i,
        output abort_i,
        output stage_done_i,
        input  pos_req_o,
        input  stage_start_o,
        input  ack_o,
        input  err_o,
        input  err_stage_o,
        input  aborted_o,
        input  busy_o,
        input  row_o,
        input  stage_o
    );

    modport slave (
        input  req_i,
        input  height_i,
        input  abort_i,
        input  stage_done_i,
        output pos_req_o,
        output stage_start_o,
        output ack_o,
        output err_o,
        output err_stage_o,
        output aborted_o,
        output busy_o,
        output row_o,
        output stage_o
    );
endinterface

// File: rtl/row_stage_sequencer.sv
// Row-loop sequencer: per row, runs NSTAGE engines in order with start/done
// handshakes, a per-stage watchdog and abort; pulses ack_o when the frame ends.
module row_stage_sequencer #(
    parameter int HEIGHT_W = 9,
    parameter int NSTAGE   = 3,
    parameter int TIMEOUT  = 65535,
    parameter int TO_W     = 16
) (
    input  logic clk,
    input  logic rstn,
    row_stage_sequencer_if.slave bus
);
    localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [SW-1:0]   LAST_STAGE = SW'(NSTAGE - 1);
    localparam bit              WD_EN      = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] WD_LAST    = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic                r_req1;
    logic                r_req2;
    logic [HEIGHT_W-1:0] r_hgt;
    logic [HEIGHT_W-1:0] r_row;
    logic [SW-1:0]       r_stage;
    logic [SW-1:0]       r_err_stage;
    logic [NSTAGE-1:0]   r_start;
    logic                r_ack;
    logic                r_err;
    logic                r_aborted;
    logic                r_busy;
    logic [TO_W-1:0]     r_wd;

    logic                w_pos;
    logic [NSTAGE-1:0]   w_sel;
    logic                w_done;
    logic                w_last;
    logic                w_wd_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_req1 <= 1'b0;
            r_req2 <= 1'b0;
        end else begin
            r_req1 <= bus.req_i;
            r_req2 <= r_req1;
        end
    end

    assign w_pos    = r_req1 & ~r_req2;
    assign w_sel    = NSTAGE'(1) << r_stage;
    assign w_done   = |(bus.stage_done_i & w_sel);
    assign w_last   = (r_stage == LAST_STAGE);
    assign w_wd_hit = WD_EN && (r_wd == WD_LAST);

    // Abort outranks done, done outranks the watchdog.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_hgt       <= '0;
            r_row       <= '0;
            r_stage     <= '0;
            r_err_stage <= '0;
            r_start     <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_aborted   <= 1'b0;
            r_busy      <= 1'b0;
            r_wd        <= '0;
        end else begin
            r_start <= '0;
            r_ack   <= 1'b0;
            if (r_state != S_IDLE && bus.abort_i) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_pos) begin
                            r_hgt     <= bus.height_i;
                            r_row     <= '0;
                            r_stage   <= '0;
                            r_err     <= 1'b0;
                            r_aborted <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_ROW;
                        end
                    end
                    S_ROW: begin
                        if (r_row == r_hgt) begin
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_stage <= '0;
                            r_start <= NSTAGE'(1);
                            r_wd    <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_done) begin
                            if (w_last) begin
                                r_row   <= r_row + HEIGHT_W'(1);
                                r_state <= S_ROW;
                            end else begin
                                r_stage <= r_stage + SW'(1);
                                r_start <= w_sel << 1;
                                r_wd    <= '0;
                            end
                        end else if (w_wd_hit) begin
                            r_err       <= 1'b1;
                            r_err_stage <= r_stage;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_wd <= r_wd + TO_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pos_req_o     = w_pos;
    assign bus.stage_start_o = r_start;
    assign bus.ack_o         = r_ack;
    assign bus.err_o         = r_err;
    assign bus.err_stage_o   = r_err_stage;
    assign bus.aborted_o     = r_aborted;
    assign bus.busy_o        = r_busy;
    assign bus.row_o         = r_row;
    assign bus.stage_o       = r_stage;
endmodule
